keypad_scan_4x4: RTL and testbench

Scanned 4x4 matrix-keypad reader: the input-side counterpart of the multiplexed 7-segment display driver. It drives one keypad column low at a time and samples the four row lines. The sampled matrix is debounced over whole scans, and each clean single-key press is reported as a 4-bit hex code with a one-cycle strobe. The block sits between the board keypad pins and the digit/counter logic feeding the display path.

---
 rtl/keypad_scan_4x4.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scan_4x4.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: scanned 4x4 matrix-keypad reader.
// Drives one column low at a time and samples the four row lines at the end of
// each column slot. The scanned 16-bit matrix is debounced over whole scans, and
// every clean single-key press is reported as a hex code with a one-cycle strobe.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   row_n[3:0] keypad rows, active-low, asynchronous to clk
//   col_n[3:0] column drive, active-low one-hot
//   key_code   code of the last accepted key (row*4 + col)
//   key_valid  one-cycle strobe when key_code is updated
//   key_down   high while the debounced matrix has any key pressed
module keypad_scan_4x4 #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned STB_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

    logic [3:0]       row_s1_q, row_s2_q;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_n_q;
    logic [15:0]      snap_q, snap_d;
    logic [15:0]      prev_q, prev_d;
    logic [15:0]      deb_q, deb_d;
    logic [STB_W-1:0] stable_q, stable_d;
    state_e           state_q, state_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q;

    logic             slot_last;
    logic             scan_end;
    logic             deb_upd;
    logic             deb_none;
    logic             deb_single;
    logic [3:0]       hit_idx;

    // Two-flop synchroniser for the asynchronous row lines; idle level is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
        end
    end

    // Slot counter, column rotation and sampling into the snapshot.
    always_comb begin
        slot_last  = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
        scan_end   = slot_last && (col_q == 2'd3);
        slot_cnt_d = slot_last ? '0 : slot_cnt_q + CNT_W'(1);
        col_d      = slot_last ? col_q + 2'd1 : col_q;
        snap_d     = snap_q;
        if (slot_last) begin
            for (int r = 0; r < 4; r++) begin
                snap_d[{2'(r), col_q}] = ~row_s2_q[r];
            end
        end
    end

    // Whole-scan debounce: the snapshot compared at scan end already holds the
    // column-3 sample taken in the same cycle.
    always_comb begin
        prev_d   = prev_q;
        stable_d = stable_q;
        deb_upd  = 1'b0;
        if (scan_end) begin
            prev_d = snap_d;
            if (snap_d == prev_q) begin
                stable_d = (stable_q == STB_W'(DEBOUNCE_SCANS)) ? stable_q
                                                               : stable_q + STB_W'(1);
            end else begin
                stable_d = STB_W'(1);
            end
            deb_upd = (stable_d == STB_W'(DEBOUNCE_SCANS));
        end
        deb_d = deb_upd ? snap_d : deb_q;
    end

    // Matrix classification: only "no key", "exactly one key" or "more" matters.
    always_comb begin
        deb_none   = (deb_d == 16'd0);
        deb_single = !deb_none && ((deb_d & (deb_d - 16'd1)) == 16'd0);
        hit_idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (deb_d[i]) begin
                hit_idx = 4'(i);
            end
        end
    end

    // Press FSM state register. The FSM consumes the freshly debounced matrix at
    // the update edge, so its decision is visible in the cycle after the update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    // Press FSM next state.
    always_comb begin
        state_d = state_q;
        if (deb_upd) begin
            unique case (state_q)
                ST_RELEASED: begin
                    if (deb_single)     state_d = ST_PRESSED;
                    else if (!deb_none) state_d = ST_LOCKED;
                end
                ST_PRESSED: begin
                    if (deb_none)        state_d = ST_RELEASED;
                    else if (!deb_single) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (deb_none)        state_d = ST_RELEASED;
                end
                default: state_d = ST_RELEASED;
            endcase
        end
    end

    // Press FSM outputs: only a release-to-single transition accepts a code.
    always_comb begin
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (deb_upd && (state_q == ST_RELEASED) && deb_single) begin
            key_valid_d = 1'b1;
            key_code_d  = hit_idx;
        end
    end

    // Scan/debounce registers and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_cnt_q  <= '0;
            col_q       <= 2'd0;
            col_n_q     <= 4'b1110;
            snap_q      <= 16'd0;
            prev_q      <= 16'd0;
            deb_q       <= 16'd0;
            stable_q    <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            col_q       <= col_d;
            col_n_q     <= ~(4'd1 << col_d);
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            deb_q       <= deb_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= |deb_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Testbench for keypad_scan_4x4 with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scan).
// A keypad model closes row r while key (r,c) is held and column c is driven low.
// A scan-level reference model predicts every output cycle by cycle.
module tb_keypad_scan_4x4;

    localparam int SD  = 4;
    localparam int DB  = 3;
    localparam int SCN = 4 * SD;

    logic       clk;
    logic       rstn;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys;
    int          cyc;

    int checks;
    int errors;

    // Strobe bookkeeping per scenario.
    int n_strobe;
    int first_valid;
    int down_rise;
    bit last_down;

    // Reference model state.
    logic [15:0] m_kd1, m_kd2, m_snap, m_prev, m_deb;
    int          m_stable;
    int          m_state;   // 0 released, 1 pressed, 2 locked
    int          m_code;
    bit          m_valid;
    bit          m_down;

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          exp_strobes;
        int          exp_code;
        bit          exp_down;
    } vec_t;

    vec_t vecs [9];

    keypad_scan_4x4 #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a held key shorts its row to the active column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    // Cycle index since reset release.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_kd1 = '0; m_kd2 = '0; m_snap = '0; m_prev = '0; m_deb = '0;
        m_stable = 0; m_state = 0; m_code = 0; m_valid = 0; m_down = 0;
    endtask

    // Advance the model by cycle t; afterwards it holds the outputs for cycle t+1.
    // A row level reaches the sampler two cycles after it is applied.
    task automatic model_step(input int t);
        int n;
        int c;
        if (t % SD == SD - 1) begin
            c = (t / SD) % 4;
            for (int r = 0; r < 4; r++) m_snap[r*4+c] = m_kd2[r*4+c];
        end
        m_valid = 0;
        if (t % SCN == SCN - 1) begin
            if (m_snap == m_prev) m_stable = (m_stable + 1 > DB) ? DB : m_stable + 1;
            else                  m_stable = 1;
            m_prev = m_snap;
            if (m_stable == DB) begin
                m_deb = m_snap;
                n = $countones(m_deb);
                case (m_state)
                    0: begin
                        if (n == 1) begin
                            m_state = 1;
                            m_valid = 1;
                            for (int i = 0; i < 16; i++) if (m_deb[i]) m_code = i;
                        end else if (n > 1) begin
                            m_state = 2;
                        end
                    end
                    1: begin
                        if (n == 0)     m_state = 0;
                        else if (n > 1) m_state = 2;
                    end
                    default: if (n == 0) m_state = 0;
                endcase
            end
        end
        m_down = |m_deb;
        m_kd2 = m_kd1;
        m_kd1 = keys;
    endtask

    // One cycle: compare at the negedge, update the model, move to next negedge.
    task automatic cycle();
        logic [3:0] exp_col;
        exp_col = ~(4'd1 << ((cyc / SD) % 4));
        chk("col_n",     int'(col_n),     int'(exp_col));
        chk("key_valid", int'(key_valid), int'(m_valid));
        chk("key_code",  int'(key_code),  m_code);
        chk("key_down",  int'(key_down),  int'(m_down));
        if (key_valid) begin
            n_strobe++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (key_down && !last_down && down_rise < 0) down_rise = cyc;
        last_down = key_down;
        model_step(cyc);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset taken at a negedge; outputs must clear at once.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_col_n",     int'(col_n),     4'b1110);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_key_down",  int'(key_down),  0);
        chk("rst_key_code",  int'(key_code),  0);
        model_reset();
        n_strobe = 0; first_valid = -1; down_rise = -1; last_down = 0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int strobes_early;
        int kind;
        int hold;
        logic [15:0] k;

        vecs[0] = '{16'h0000,            4, 0, 9, 1'b0};  // release key 9
        vecs[1] = '{16'h8010,            4, 0, 9, 1'b1};  // (1,0)+(3,3): locked
        vecs[2] = '{16'h0010,            4, 0, 9, 1'b1};  // drop (3,3): still locked
        vecs[3] = '{16'h0000,            4, 0, 9, 1'b0};  // full release
        vecs[4] = '{16'h0010,            4, 1, 4, 1'b1};  // (1,0) accepted
        vecs[5] = '{16'h0000,            4, 0, 4, 1'b0};
        vecs[6] = '{16'h0001,            4, 1, 0, 1'b1};  // (0,0) accepted
        vecs[7] = '{16'h4000,            4, 0, 0, 1'b1};  // roll-over to (3,2)
        vecs[8] = '{16'h0000,            4, 0, 0, 1'b0};

        checks = 0;
        errors = 0;
        keys   = '0;
        rstn   = 1'b0;
        @(negedge clk);

        // Idle scan: column rotation, all outputs quiet.
        do_reset();
        run(3 * SCN);
        chk("idle_strobes", n_strobe, 0);

        // Single press of (2,1) from reset release: accept at cycle 48.
        do_reset();
        keys = 16'h0200;
        run(4 * SCN);
        chk("press_valid_cyc", first_valid, 48);
        chk("press_down_cyc",  down_rise,   48);
        chk("press_strobes",   n_strobe,    1);
        chk("press_code",      int'(key_code), 9);

        // Table of scan-aligned key patterns continuing from the press above.
        for (int v = 0; v < 9; v++) begin
            n_strobe = 0;
            keys = vecs[v].keys;
            run(vecs[v].scans * SCN);
            chk($sformatf("vec%0d_strobes", v), n_strobe,       vecs[v].exp_strobes);
            chk($sformatf("vec%0d_code", v),    int'(key_code), vecs[v].exp_code);
            chk($sformatf("vec%0d_down", v),    int'(key_down), int'(vecs[v].exp_down));
        end

        // Bounce on (0,3): toggle every 10 cycles from cycle 8 for 100 cycles, then hold.
        do_reset();
        strobes_early = 0;
        for (int t = 0; t < 10 * SCN; t++) begin
            if (t >= 108)                        keys = 16'h0008;
            else if (t >= 8 && ((t - 8) / 10) % 2 == 0) keys = 16'h0008;
            else                                 keys = 16'h0000;
            if (t < 108 && key_valid) strobes_early++;
            cycle();
        end
        chk("bounce_early_strobes", strobes_early,  0);
        chk("bounce_strobes",       n_strobe,       1);
        chk("bounce_code",          int'(key_code), 3);

        // Reset during the 2nd identical scan of (1,1), after (0,3) was accepted.
        do_reset();
        keys = 16'h0008;
        run(4 * SCN);
        keys = 16'h0000;
        run(4 * SCN);
        chk("pre_rst_code", int'(key_code), 3);
        keys = 16'h0020;
        run(SCN + SCN / 2);
        do_reset();
        run(4 * SCN);
        chk("rst_valid_cyc", first_valid,    48);
        chk("rst_strobes",   n_strobe,       1);
        chk("rst_code",      int'(key_code), 5);

        // Randomised scan-aligned patterns against the model.
        do_reset();
        for (int s = 0; s < 40; s++) begin
            kind = int'($urandom_range(0, 3));
            k = 16'h0000;
            if (kind == 1 || kind == 2) k = 16'(1) << $urandom_range(0, 15);
            if (kind == 3) k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            hold = int'($urandom_range(1, 5));
            keys = k;
            run(hold * SCN);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
